// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default operand width and the divider state encoding.
package mips_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// Handshake and result bundle between the control unit (master) and the HI/LO divider (slave).
interface div_if #(parameter int WIDTH = mips_pkg::WIDTH);

  logic             div_start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             div_end;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output div_start, A, B,
                  input  busy, div_end, div_zero, hi, lo);

  modport slave  (input  div_start, A, B,
                  output busy, div_end, div_zero, hi, lo);

endinterface

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {R,Q} left, trial-subtract D, set the new quotient bit.
module div_step #(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // R < D <= 2^(WIDTH-1) keeps the shifted remainder inside WIDTH bits, so
  // diff[WIDTH] is a reliable sign of the trial subtraction.
  assign rem_sh = {r, q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, d};

  assign r_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_nxt = {q[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div.sv
// Iterative signed divider for the HI/LO unit: lo = A / B (toward zero), hi = A % B (sign of A).
// One quotient bit per clock on magnitudes, then a single sign fix-up cycle.
module div
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             end_q, end_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] r_step, q_step;

  // Unsigned magnitudes: the most negative operand maps onto itself without overflow.
  assign mag_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign mag_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r_q),
    .q     (q_q),
    .d     (d_q),
    .r_nxt (r_step),
    .q_nxt (q_step)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    r_d      = r_q;
    d_d      = d_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    end_d    = 1'b0;
    zero_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.div_start) begin
          q_d      = mag_a;
          d_d      = mag_b;
          r_d      = '0;
          cnt_d    = '0;
          sign_q_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          sign_r_d = bus.A[WIDTH-1];
          state_d  = (bus.B == '0) ? ZERO : RUN;
        end
      end
      RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = sign_q_q ? -q_q : q_q;
        hi_d    = sign_r_q ? -r_q : r_q;
        end_d   = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        end_d   = 1'b1;
        zero_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      end_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      r_q      <= r_d;
      d_q      <= d_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      end_q    <= end_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.div_end  = end_q;
  assign bus.div_zero = zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
